stream_recorder_player: RTL and testbench



---
 rtl/recplay_pkg.sv | 20 ++
 rtl/stream_recorder_player_if.sv | 17 +
 rtl/recplay_ram.sv | 21 ++
 rtl/stream_recorder_player.sv | 216 +++++++++++++++++++++
 tb/tb_stream_recorder_player.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/recplay_pkg.sv
// Shared types for the stream recorder/player: FSM state encodings and the
// pass-counter width.
package recplay_pkg;

   localparam int LOOP_W = 8;

   typedef enum logic [1:0] {
      REC_IDLE,
      REC_REC,
      REC_DONE
   } RecState_t;

   typedef enum logic [1:0] {
      PLAY_IDLE,
      PLAY_PLAY,
      PLAY_DRAIN,
      PLAY_DONE
   } PlayState_t;

endpackage

// File: rtl/stream_recorder_player_if.sv
// AXI4-Stream style beat bundle (data/valid/last/ready) used for both the
// record input and the playback output.
//
// Handshake: a beat transfers on a rising edge where valid & ready are both
// high. Once valid is asserted, data and last stay stable and valid stays high
// until that transfer. ready may change freely.
interface stream_recorder_player_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  last;
   logic                  ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/recplay_ram.sv
// Simple dual-port frame buffer: one write port, one registered read port.
// The array has no reset.
module recplay_ram #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  re,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);
   logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/stream_recorder_player.sv
// Records one stream frame into RAM and replays it once, N times or forever.
// Optional build macro RECPLAY_BYPASS_EN: pass-through in_* -> out_* while idle.
module stream_recorder_player
   import recplay_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    record,
   input  logic                    play,
   input  logic [LOOP_W-1:0]       loop_count,
   stream_recorder_player_if.slave  in_s,
   stream_recorder_player_if.master out_m,
   output logic [ADDR_WIDTH:0]     recorded_len,
   output logic                    truncated,
   output logic                    busy,
   output RecState_t               rec_state,
   output PlayState_t              play_state
);
   localparam int LW = ADDR_WIDTH + 1;
   localparam logic [LW-1:0] DEPTH = LW'(1 << ADDR_WIDTH);

   RecState_t             rec_state_q, rec_state_d;
   PlayState_t            play_state_q, play_state_d;
   logic [LW-1:0]         wr_ptr_q, wr_ptr_d, len_q, len_d, rd_ptr_q, rd_ptr_d;
   logic                  trunc_q, trunc_d;
   logic [LOOP_W-1:0]     pass_q, pass_d;
   logic                  issue_done_q, issue_done_d;
   logic                  rd_vld_q, rd_vld_d, rd_last_q, rd_last_d, rd_fin_q, rd_fin_d;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic                  out_fin_q, out_fin_d;
   logic                  busy_q, busy_d;
   logic                  rec_ready, accept, rd_en, out_load, word_last, pass_final;
   logic                  start_ok;
   logic [DATA_WIDTH-1:0] ram_rdata;

`ifdef RECPLAY_BYPASS_EN
   logic both_idle, bypass;
   // A beat stalled mid-handshake keeps the pass-through alive until it moves.
   assign both_idle = (rec_state_q == REC_IDLE) && (play_state_q == PLAY_IDLE);
   assign start_ok  = !(in_s.valid && !out_m.ready);
   assign bypass    = both_idle && !((record || play) && start_ok);
   assign in_s.ready  = bypass ? out_m.ready : rec_ready;
   assign out_m.valid = bypass ? in_s.valid  : out_valid_q;
   assign out_m.data  = bypass ? in_s.data   : out_data_q;
   assign out_m.last  = bypass ? in_s.last   : out_last_q;
`else
   assign start_ok    = 1'b1;
   assign in_s.ready  = rec_ready;
   assign out_m.valid = out_valid_q;
   assign out_m.data  = out_data_q;
   assign out_m.last  = out_last_q;
`endif

   assign rec_ready    = (rec_state_q == REC_REC) && !wr_ptr_q[ADDR_WIDTH];
   assign accept       = rec_ready && in_s.valid;
   assign recorded_len = len_q;
   assign truncated    = trunc_q;
   assign busy         = busy_q;
   assign rec_state    = rec_state_q;
   assign play_state   = play_state_q;

   recplay_ram #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
      .wdata (in_s.data),
      .re    (rd_en),
      .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
      .rdata (ram_rdata)
   );

   always_comb begin : rec_fsm
      rec_state_d = rec_state_q;
      wr_ptr_d    = wr_ptr_q;
      len_d       = len_q;
      trunc_d     = trunc_q;
      case (rec_state_q)
         REC_IDLE: if (record && play_state_q == PLAY_IDLE && start_ok) begin
            rec_state_d = REC_REC;
            wr_ptr_d    = '0;
            len_d       = '0;
            trunc_d     = 1'b0;
         end
         REC_REC: begin
            if (accept) wr_ptr_d = wr_ptr_q + LW'(1);
            if (accept && (in_s.last || wr_ptr_d == DEPTH)) begin
               rec_state_d = REC_DONE;
               len_d       = wr_ptr_d;
               trunc_d     = !in_s.last;
            end else if (!record) begin
               rec_state_d = REC_IDLE;
               len_d       = wr_ptr_d;
            end
         end
         REC_DONE: if (!record) rec_state_d = REC_IDLE;
         default:  rec_state_d = REC_IDLE;
      endcase
   end

   // Reads are issued only when the one-word prefetch slot will be free, so the
   // RAM output itself holds the prefetched word while the output is stalled.
   assign word_last  = (rd_ptr_q == len_q - LW'(1));
   assign pass_final = (loop_count != '0) && (pass_q == loop_count - LOOP_W'(1));
   assign out_load   = (play_state_q == PLAY_PLAY) && rd_vld_q && (!out_valid_q || out_m.ready);
   assign rd_en      = (play_state_q == PLAY_PLAY) && (len_q != '0) && !issue_done_q &&
                       (!rd_vld_q || out_load);

   always_comb begin : play_fsm
      play_state_d = play_state_q;
      rd_ptr_d     = rd_ptr_q;
      pass_d       = pass_q;
      issue_done_d = issue_done_q;
      rd_vld_d     = rd_vld_q;
      rd_last_d    = rd_last_q;
      rd_fin_d     = rd_fin_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      out_last_d   = out_last_q;
      out_fin_d    = out_fin_q;

      if (rd_en) begin
         rd_vld_d  = 1'b1;
         rd_last_d = word_last;
         rd_fin_d  = word_last && pass_final;
         if (word_last) begin
            rd_ptr_d     = '0;
            pass_d       = pass_q + LOOP_W'(1);
            issue_done_d = pass_final;
         end else begin
            rd_ptr_d = rd_ptr_q + LW'(1);
         end
      end else if (out_load) begin
         rd_vld_d = 1'b0;
      end

      if (out_load) begin
         out_valid_d = 1'b1;
         out_data_d  = ram_rdata;
         out_last_d  = rd_last_q;
         out_fin_d   = rd_fin_q;
      end else if (out_m.ready) begin
         out_valid_d = 1'b0;
      end

      case (play_state_q)
         PLAY_IDLE: if (play && !record && rec_state_q == REC_IDLE && start_ok) begin
            play_state_d = PLAY_PLAY;
            rd_ptr_d     = '0;
            pass_d       = '0;
            issue_done_d = 1'b0;
            rd_vld_d     = 1'b0;
            out_valid_d  = 1'b0;
         end
         PLAY_PLAY: begin
            if (!play) begin
               play_state_d = PLAY_DRAIN;
               rd_vld_d     = 1'b0;
            end else if (len_q == '0) begin
               play_state_d = PLAY_DONE;
            end else if (out_valid_q && out_m.ready && out_fin_q) begin
               play_state_d = PLAY_DONE;
            end
         end
         PLAY_DRAIN: begin
            rd_vld_d = 1'b0;
            if (!out_valid_d) play_state_d = PLAY_IDLE;
         end
         PLAY_DONE: if (!play) play_state_d = PLAY_IDLE;
         default:   play_state_d = PLAY_IDLE;
      endcase

      busy_d = (rec_state_d != REC_IDLE) || (play_state_d != PLAY_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rec_state_q  <= REC_IDLE;
         play_state_q <= PLAY_IDLE;
         wr_ptr_q     <= '0;
         len_q        <= '0;
         trunc_q      <= 1'b0;
         rd_ptr_q     <= '0;
         pass_q       <= '0;
         issue_done_q <= 1'b0;
         rd_vld_q     <= 1'b0;
         rd_last_q    <= 1'b0;
         rd_fin_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         out_fin_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         rec_state_q  <= rec_state_d;
         play_state_q <= play_state_d;
         wr_ptr_q     <= wr_ptr_d;
         len_q        <= len_d;
         trunc_q      <= trunc_d;
         rd_ptr_q     <= rd_ptr_d;
         pass_q       <= pass_d;
         issue_done_q <= issue_done_d;
         rd_vld_q     <= rd_vld_d;
         rd_last_q    <= rd_last_d;
         rd_fin_q     <= rd_fin_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         out_last_q   <= out_last_d;
         out_fin_q    <= out_fin_d;
         busy_q       <= busy_d;
      end
   end
endmodule

// File: tb/tb_stream_recorder_player.sv
// Randomized bench for stream_recorder_player (ADDR_WIDTH 3) against a
// queue-based model of the recorded frame and the expected replay stream.
module tb_stream_recorder_player;
   import recplay_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 3;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          reset, record, play;
   logic [7:0]    loop_count;
   logic [AW:0]   recorded_len;
   logic          truncated, busy;
   RecState_t     rec_state;
   PlayState_t    play_state;

   stream_recorder_player_if #(.DATA_WIDTH(DW)) in_if ();
   stream_recorder_player_if #(.DATA_WIDTH(DW)) out_if ();

   stream_recorder_player #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .reset        (reset),
      .record       (record),
      .play         (play),
      .loop_count   (loop_count),
      .in_s         (in_if),
      .out_m        (out_if),
      .recorded_len (recorded_len),
      .truncated    (truncated),
      .busy         (busy),
      .rec_state    (rec_state),
      .play_state   (play_state)
   );

   always #5 clk = ~clk;

   // Model: the committed frame as the recorder should hold it.
   logic [DW-1:0] frame[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] beat_of(input logic v, input logic l, input logic [DW-1:0] d);
      return {22'd0, v, l, d};
   endfunction

   function automatic logic [31:0] frame_beat(input int idx);
      int len = frame.size();
      return beat_of(1'b1, (idx % len) == len - 1, frame[idx % len]);
   endfunction

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_in_ready"},  32'(in_if.ready), 0);
      check_val({tag, "_out_valid"}, 32'(out_if.valid), 0);
      check_val({tag, "_out_last"},  32'(out_if.last), 0);
      check_val({tag, "_out_data"},  32'(out_if.data), 0);
      check_val({tag, "_rec_len"},   32'(recorded_len), 0);
      check_val({tag, "_trunc"},     32'(truncated), 0);
      check_val({tag, "_busy"},      32'(busy), 0);
   endtask

   // Offer n words; the model decides which ones the recorder must take.
   task automatic record_frame(input int n, input bit with_last, input bit inc_data, input bit gaps);
      logic [DW-1:0] d;
      logic [DW-1:0] newf[$];
      int  acc = 0;
      bit  last_acc = 0;
      bit  done;
      @(negedge clk); record = 1'b1;
      @(negedge clk); #1;
      check_val("rec_state_rec", 32'(rec_state), 32'(REC_REC));
      check_val("rec_busy", 32'(busy), 1);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            in_if.valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         d = inc_data ? DW'(8'h11 + i) : DW'($urandom);
         in_if.data  = d;
         in_if.valid = 1'b1;
         in_if.last  = with_last && (i == n - 1);
         #1;
         check_val("in_ready", 32'(in_if.ready), 32'(acc < DEPTH && !last_acc));
         if (acc < DEPTH && !last_acc) begin
            newf.push_back(d);
            acc++;
            if (in_if.last) last_acc = 1;
         end
         @(negedge clk);
      end
      in_if.valid = 1'b0;
      in_if.last  = 1'b0;
      #1;
      done = (acc == DEPTH) || last_acc;
      check_val("in_ready_after", 32'(in_if.ready), 32'(!done));
      if (done) check_val("len_at_done", 32'(recorded_len), acc);
      record = 1'b0;
      @(negedge clk); #1;
      check_val("rec_len", 32'(recorded_len), acc);
      check_val("truncated", 32'(truncated), 32'(acc == DEPTH && !last_acc));
      check_val("rec_idle", 32'(rec_state), 32'(REC_IDLE));
      check_val("rec_busy_low", 32'(busy), 0);
      frame = newf;
   endtask

   // Replay lc passes with the given stall percentage and score every beat.
   task automatic play_run(input int lc, input int stall_pct, input bit check_lat);
      logic [DW:0] exp_q[$];
      logic [DW:0] e;
      logic [31:0] held_v = '0;
      bit held = 0;
      bit seen = 0;
      int cyc = 0;
      for (int p = 0; p < lc; p++)
         for (int i = 0; i < frame.size(); i++)
            exp_q.push_back({i == frame.size() - 1, frame[i]});
      @(negedge clk);
      loop_count = 8'(lc);
      play = 1'b1;
      while (exp_q.size() > 0 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         out_if.ready = ($urandom_range(0, 99) >= stall_pct);
         #1;
         if (out_if.valid && !seen) begin
            seen = 1;
            if (check_lat) check_val("first_valid_lat", cyc, 3);
         end
         if (held) check_val("stall_hold", beat_of(out_if.valid, out_if.last, out_if.data), held_v);
         if (seen && stall_pct == 0) check_val("no_bubble", 32'(out_if.valid), 1);
         if (out_if.valid && out_if.ready) begin
            e = exp_q.pop_front();
            check_val("beat", beat_of(1'b1, out_if.last, out_if.data), beat_of(1'b1, e[DW], e[DW-1:0]));
         end
         held   = out_if.valid && !out_if.ready;
         held_v = beat_of(out_if.valid, out_if.last, out_if.data);
      end
      if (exp_q.size() > 0) check_val("play_timeout", exp_q.size(), 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); #1;
         check_val("post_valid", 32'(out_if.valid), 0);
         check_val("play_done", 32'(play_state), 32'(PLAY_DONE));
      end
      play = 1'b0;
      @(negedge clk); #1;
      check_val("play_idle", 32'(play_state), 32'(PLAY_IDLE));
      check_val("play_busy_low", 32'(busy), 0);
   endtask

   // Continuous replay, then drop play while the output is stalled.
   task automatic drain_test();
      int idx = 0;
      int cyc = 0;
      @(negedge clk);
      loop_count = 8'd0;
      play = 1'b1;
      out_if.ready = 1'b1;
      while (idx < frame.size() + 2 && cyc < 100) begin
         @(negedge clk); cyc++; #1;
         if (out_if.valid) begin
            check_val("loop0_beat", beat_of(1'b1, out_if.last, out_if.data), frame_beat(idx));
            idx++;
         end
      end
      check_val("loop0_count", idx, frame.size() + 2);
      @(negedge clk);
      out_if.ready = 1'b0;
      #1;
      check_val("drain_stall", beat_of(out_if.valid, out_if.last, out_if.data), frame_beat(idx));
      @(negedge clk);
      play = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_val("drain_hold", beat_of(out_if.valid, out_if.last, out_if.data), frame_beat(idx));
         @(negedge clk);
      end
      out_if.ready = 1'b1;
      #1;
      check_val("drain_accept", beat_of(out_if.valid, out_if.last, out_if.data), frame_beat(idx));
      @(negedge clk); #1;
      check_val("drain_valid_low", 32'(out_if.valid), 0);
      check_val("drain_busy_low", 32'(busy), 0);
      check_val("drain_idle", 32'(play_state), 32'(PLAY_IDLE));
   endtask

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbeats;
      reset = 1'b1; record = 1'b0; play = 1'b0; loop_count = 8'd0;
      in_if.data = '0; in_if.valid = 1'b0; in_if.last = 1'b0; out_if.ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      record_frame(5, 1'b1, 1'b1, 1'b0);
      play_run(3, 0, 1'b1);
      play_run(2, 40, 1'b0);

      record_frame(10, 1'b0, 1'b0, 1'b0);
      play_run(1, 30, 1'b0);

      for (int t = 0; t < 3; t++) begin
         record_frame($urandom_range(1, DEPTH), 1'b1, 1'b0, 1'b1);
         play_run($urandom_range(1, 3), 25, 1'b0);
      end

      drain_test();

      // Reset during continuous playback.
      @(negedge clk);
      loop_count = 8'd0; play = 1'b1; out_if.ready = 1'b1;
      repeat (6) @(negedge clk);
      reset = 1'b1;
      #1;
      check_reset_outputs("midreset");
      play = 1'b0;
      frame.delete();
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // record and play together: record wins, play waits for the recorder.
      @(negedge clk);
      record = 1'b1; play = 1'b1; loop_count = 8'd1;
      @(negedge clk); #1;
      check_val("both_rec_state", 32'(rec_state), 32'(REC_REC));
      check_val("both_play_state", 32'(play_state), 32'(PLAY_IDLE));
      record = 1'b0;
      @(negedge clk); #1;
      check_val("both_rec_idle", 32'(rec_state), 32'(REC_IDLE));
      check_val("empty_rec_len", 32'(recorded_len), 0);

      // Playback of an empty recording finishes with no beats.
      nbeats = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); #1;
         if (out_if.valid) nbeats++;
      end
      check_val("empty_beats", nbeats, 0);
      check_val("empty_done", 32'(play_state), 32'(PLAY_DONE));
      play = 1'b0;
      @(negedge clk); #1;
      check_val("empty_busy_low", 32'(busy), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
